// File: rtl/pipe_mem_stage_if.sv
// Data-memory bus between the MEM pipeline stage and the data memory.
// The stage drives the request side; the memory answers with read data and
// an acknowledge that is only meaningful while a request is outstanding.
interface pipe_mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/pipe_mem_stage.sv
// MEM stage of a five-stage pipeline: issues loads/stores to a data memory
// with a variable-latency acknowledge, stalls earlier stages while waiting,
// and owns the MEM/WB pipeline register.
// Optional feature: define PIPEMEM_TIMEOUT_EN to abort accesses that are not
// acknowledged within TIMEOUT_CYCLES and raise the sticky merr flag.
module pipe_mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      mwreg,
  input  logic                      mm2reg,
  input  logic                      mwmem,
  input  logic [31:0]               malu,
  input  logic [31:0]               mb,
  input  logic [4:0]                mrn,
  pipe_mem_stage_if.master          dmem,
  output logic                      mstall,
  output logic                      wwreg,
  output logic                      wm2reg,
  output logic [31:0]               wmo,
  output logic [31:0]               walu,
  output logic [4:0]                wrn,
  output logic                      merr
);

  generate
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 31) begin : g_bad_timeout
      $error("pipe_mem_stage: TIMEOUT_CYCLES must be within 2..31");
    end
  endgenerate

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state;
  state_t next_state;
  logic   memop;
  logic   abort;
  logic   load_done;

  // A load wins when both load and store controls are set.
  assign memop            = mm2reg | mwmem;
  assign dmem.dmem_we     = mwmem & ~mm2reg;
  assign dmem.dmem_addr   = malu;
  assign dmem.dmem_wdata  = mb;
  assign dmem.dmem_req    = clr ? 1'b0 : ((state == WAIT) ? 1'b1 : memop);
  assign mstall           = dmem.dmem_req & ~dmem.dmem_ack & ~abort;
  assign load_done        = dmem.dmem_req & dmem.dmem_ack & mm2reg;

`ifdef PIPEMEM_TIMEOUT_EN
  localparam logic [4:0] LIMIT = 5'(TIMEOUT_CYCLES - 1);

  logic [4:0] wait_cnt;

  assign abort = (state == WAIT) & ~clr & ~dmem.dmem_ack & (wait_cnt == LIMIT);

  // Count cycles spent waiting; the count restarts whenever the FSM returns to IDLE.
  always_ff @(posedge clk) begin
    if (clr || next_state == IDLE) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 5'd1;
    end
  end

  // Sticky error flag recording that an access was abandoned by timeout.
  always_ff @(posedge clk) begin
    if (clr) begin
      merr <= 1'b0;
    end else if (abort) begin
      merr <= 1'b1;
    end
  end
`else
  assign abort = 1'b0;
  assign merr  = 1'b0;
`endif

  // Next-state logic: enter WAIT on an unacknowledged access, leave on ack or abort.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (memop && !dmem.dmem_ack && !clr) next_state = WAIT;
      WAIT: if (dmem.dmem_ack || abort) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // MEM/WB register: bubble while stalled, capture otherwise, squash writeback on abort.
  always_ff @(posedge clk) begin
    if (clr) begin
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
      wmo    <= '0;
      walu   <= '0;
      wrn    <= '0;
    end else if (mstall) begin
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
    end else if (abort) begin
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
      walu   <= malu;
      wrn    <= mrn;
    end else begin
      wwreg  <= mwreg;
      wm2reg <= mm2reg;
      walu   <= malu;
      wrn    <= mrn;
      if (load_done) wmo <= dmem.dmem_rdata;
    end
  end

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Directed self-checking bench for pipe_mem_stage. Inputs change 1 ns after
// each rising edge; combinational outputs are checked before the next edge and
// registered outputs 1 ns after it. Build with PIPEMEM_TIMEOUT_EN defined to
// exercise the timeout abort path.
module tb_pipe_mem_stage;
  logic        clk = 1'b0;
  logic        clr;
  logic        mwreg, mm2reg, mwmem;
  logic [31:0] malu, mb;
  logic [4:0]  mrn;
  logic        mstall, wwreg, wm2reg, merr;
  logic [31:0] wmo, walu;
  logic [4:0]  wrn;

  int tests_run = 0;
  int tests_failed = 0;

  pipe_mem_stage_if dmem ();

  pipe_mem_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk    (clk),
    .clr    (clr),
    .mwreg  (mwreg),
    .mm2reg (mm2reg),
    .mwmem  (mwmem),
    .malu   (malu),
    .mb     (mb),
    .mrn    (mrn),
    .dmem   (dmem.master),
    .mstall (mstall),
    .wwreg  (wwreg),
    .wm2reg (wm2reg),
    .wmo    (wmo),
    .walu   (walu),
    .wrn    (wrn),
    .merr   (merr)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic wreg, input logic m2reg, input logic wmem,
                                input logic [31:0] alu, input logic [31:0] b,
                                input logic [4:0] rn, input logic ack,
                                input logic [31:0] rdata);
    mwreg           = wreg;
    mm2reg          = m2reg;
    mwmem           = wmem;
    malu            = alu;
    mb              = b;
    mrn             = rn;
    dmem.dmem_ack   = ack;
    dmem.dmem_rdata = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a pending load on the inputs: no request may escape.
    clr = 1'b1;
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd5, 1'b0, 32'h0);
    #1;
    check_output("rst_req", 32'(dmem.dmem_req), 32'd0);
    check_output("rst_stall", 32'(mstall), 32'd0);
    tick();
    tick();
    check_output("rst_wwreg", 32'(wwreg), 32'd0);
    check_output("rst_wm2reg", 32'(wm2reg), 32'd0);
    check_output("rst_wmo", wmo, 32'd0);
    check_output("rst_walu", walu, 32'd0);
    check_output("rst_wrn", 32'(wrn), 32'd0);
    check_output("rst_merr", 32'(merr), 32'd0);

    // ALU instruction passes straight through.
    clr = 1'b0;
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'd7, 32'h0, 5'd3, 1'b0, 32'h0);
    #1;
    check_output("alu_req", 32'(dmem.dmem_req), 32'd0);
    check_output("alu_stall", 32'(mstall), 32'd0);
    tick();
    check_output("alu_walu", walu, 32'd7);
    check_output("alu_wrn", 32'(wrn), 32'd3);
    check_output("alu_wwreg", 32'(wwreg), 32'd1);
    check_output("alu_wm2reg", 32'(wm2reg), 32'd0);

    // Zero-wait load.
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd5, 1'b1, 32'hDEADBEEF);
    #1;
    check_output("ld0_req", 32'(dmem.dmem_req), 32'd1);
    check_output("ld0_we", 32'(dmem.dmem_we), 32'd0);
    check_output("ld0_addr", dmem.dmem_addr, 32'h100);
    check_output("ld0_stall", 32'(mstall), 32'd0);
    tick();
    check_output("ld0_wm2reg", 32'(wm2reg), 32'd1);
    check_output("ld0_wwreg", 32'(wwreg), 32'd1);
    check_output("ld0_wmo", wmo, 32'hDEADBEEF);
    check_output("ld0_wrn", 32'(wrn), 32'd5);

    // Store acknowledged after three stall cycles.
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h40, 32'h12345678, 5'd0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_output("st_we_wait", 32'(dmem.dmem_we), 32'd1);
      check_output("st_stall", 32'(mstall), 32'd1);
      check_output("st_wdata", dmem.dmem_wdata, 32'h12345678);
      tick();
      check_output("st_bubble", 32'(wwreg), 32'd0);
      check_output("st_walu_hold", walu, 32'h100);
    end
    dmem.dmem_ack = 1'b1;
    #1;
    check_output("st_we_ack", 32'(dmem.dmem_we), 32'd1);
    check_output("st_stall_ack", 32'(mstall), 32'd0);
    tick();
    check_output("st_walu", walu, 32'h40);
    check_output("st_wwreg", 32'(wwreg), 32'd0);
    check_output("st_wmo_hold", wmo, 32'hDEADBEEF);

    // Load and store both set behaves as a load.
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'h80, 32'h55, 5'd9, 1'b1, 32'hCAFEF00D);
    #1;
    check_output("both_we", 32'(dmem.dmem_we), 32'd0);
    tick();
    check_output("both_wmo", wmo, 32'hCAFEF00D);
    check_output("both_wm2reg", 32'(wm2reg), 32'd1);
    check_output("both_wrn", 32'(wrn), 32'd9);

    // Stray acknowledge with no access outstanding.
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h22, 32'h0, 5'd2, 1'b1, 32'h11111111);
    #1;
    check_output("stray_req", 32'(dmem.dmem_req), 32'd0);
    check_output("stray_stall", 32'(mstall), 32'd0);
    tick();
    check_output("stray_wmo", wmo, 32'hCAFEF00D);
    check_output("stray_walu", walu, 32'h22);

    // Reset during the second WAIT cycle, then a late ack for the dead access.
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd7, 1'b0, 32'h0);
    tick();
    tick();
    #1;
    check_output("rw_req_wait", 32'(dmem.dmem_req), 32'd1);
    clr = 1'b1;
    #1;
    check_output("rw_req_clr", 32'(dmem.dmem_req), 32'd0);
    check_output("rw_stall_clr", 32'(mstall), 32'd0);
    tick();
    clr = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 32'hBADBAD00);
    #1;
    check_output("rw_req_after", 32'(dmem.dmem_req), 32'd0);
    check_output("rw_stall_after", 32'(mstall), 32'd0);
    check_output("rw_wmo", wmo, 32'd0);
    check_output("rw_walu", walu, 32'd0);
    check_output("rw_wrn", 32'(wrn), 32'd0);
    check_output("rw_wwreg", 32'(wwreg), 32'd0);
    tick();
    check_output("rw_wmo_stray", wmo, 32'd0);
    check_output("rw_wm2reg", 32'(wm2reg), 32'd0);

    // Load that is never acknowledged.
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd4, 1'b0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      #1;
      check_output("to_stall", 32'(mstall), 32'd1);
      tick();
    end
`ifdef PIPEMEM_TIMEOUT_EN
    #1;
    check_output("to_abort_stall", 32'(mstall), 32'd0);
    check_output("to_merr_before", 32'(merr), 32'd0);
    tick();
    check_output("to_merr", 32'(merr), 32'd1);
    check_output("to_wwreg", 32'(wwreg), 32'd0);
    check_output("to_wm2reg", 32'(wm2reg), 32'd0);
    check_output("to_walu", walu, 32'h300);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h5, 32'h0, 5'd1, 1'b0, 32'h0);
    tick();
    check_output("to_merr_sticky", 32'(merr), 32'd1);
    check_output("to_req_idle", 32'(dmem.dmem_req), 32'd0);
`else
    tick();
    tick();
    check_output("to_stall_persist", 32'(mstall), 32'd1);
    check_output("to_merr_zero", 32'(merr), 32'd0);
    check_output("to_wwreg", 32'(wwreg), 32'd0);
`endif
    clr = 1'b1;
    tick();
    check_output("end_merr_clr", 32'(merr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/pipe_mem_stage.md
PIPE_MEM_STAGE -- requirements
Module: pipe_mem_stage

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, maximum wait cycles before abort; legal range 2..31.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 clr  in  1  synchronous active-high reset, sampled on posedge clk.
REQ-004 mwreg, mm2reg, mwmem  in  1 each  EX/MEM control (register write, load, store).
REQ-005 malu  in  32  ALU result / memory address; mb  in  32  store data; mrn  in  5  destination register.
REQ-006 dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32; dmem_wdata  out  32  data-memory request.
REQ-007 dmem_rdata  in  32; dmem_ack  in  1  memory completion, valid only while dmem_req=1.
REQ-008 mstall  out  1  freeze EX/MEM and earlier stages.
REQ-009 wwreg, wm2reg  out  1 each; wmo  out  32; walu  out  32; wrn  out  5  MEM/WB register.
REQ-010 merr  out  1  sticky timeout error (only with PIPEMEM_TIMEOUT_EN).

Function
REQ-011 memop = mm2reg | mwmem; mm2reg and mwmem both high is treated as a load (dmem_we=0).
REQ-012 FSM states IDLE and WAIT; IDLE->WAIT when memop=1 and dmem_ack=0; WAIT->IDLE on dmem_ack=1 (or abort).
REQ-013 dmem_req = memop & ~clr in IDLE; 1 in WAIT; dmem_addr=malu, dmem_wdata=mb, dmem_we=mwmem&~mm2reg (combinational).
REQ-014 mstall = dmem_req & ~dmem_ack; zero-wait ack (same cycle as request) completes with no stall.
REQ-015 EX/MEM inputs are held by upstream while mstall=1; the block does not latch them.
REQ-016 Non-memop instruction: no request, mstall=0, passes to MEM/WB next edge.
REQ-017 MEM/WB update at posedge when mstall=0: wwreg<=mwreg, wm2reg<=mm2reg, walu<=malu, wrn<=mrn, wmo<=dmem_rdata if load acked else hold.
REQ-018 MEM/WB update when mstall=1: bubble -- wwreg<=0, wm2reg<=0; walu, wmo, wrn hold.
REQ-019 dmem_ack while dmem_req=0 is ignored; no state change.
REQ-020 Store completes on ack; wwreg follows mwreg (normally 0).

Reset
REQ-021 clr=1 at posedge: state<=IDLE, wwreg, wm2reg, wmo, walu, wrn, merr, wait counter <=0.
REQ-022 While clr=1 dmem_req=0 and mstall=0 regardless of state or inputs.
REQ-023 Reset during WAIT abandons the outstanding access; any later ack for it is ignored per REQ-019.

Configuration
REQ-024 Macro PIPEMEM_TIMEOUT_EN: when defined, a 5-bit wait counter increments each WAIT cycle, clears on entry to IDLE.
REQ-025 With PIPEMEM_TIMEOUT_EN: counter reaching TIMEOUT_CYCLES-1 without ack forces WAIT->IDLE, mstall=0 that cycle, MEM/WB captures with wwreg<=0, wm2reg<=0, merr<=1 (sticky until clr).
REQ-026 Without PIPEMEM_TIMEOUT_EN: no counter, WAIT persists until ack, merr tied 0.

Verification
REQ-027 Load, mm2reg=1, malu=0x100, mrn=5, ack same cycle, rdata=0xDEADBEEF -> mstall never 1; next edge wm2reg=1, wwreg=1, wmo=0xDEADBEEF, wrn=5.
REQ-028 Store, mwmem=1, malu=0x40, mb=0x12345678, ack after 3 cycles -> dmem_we=1 for 4 cycles, mstall=1 for 3 cycles, 3 bubbles (wwreg=0) then capture.
REQ-029 ALU op mwreg=1, malu=7, mrn=3 -> dmem_req=0, next edge walu=7, wrn=3, wwreg=1.
REQ-030 clr asserted in second WAIT cycle, ack one cycle later -> state IDLE, all MEM/WB outputs 0, stray ack ignored.
REQ-031 PIPEMEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, load never acked -> mstall high 16 cycles then 0, merr=1, wwreg=0; without macro mstall stays 1.
